// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller for a 16-bit, byte-selectable async SRAM.
// Optional diagnostic mode: define MBIST_DIAG_EN to run to completion and count errors.
module march_bist_ctrl #(
    parameter logic [16:0] ADDR_LAST = 17'd3,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [16:0]      fail_addr,
    output logic [15:0]      fail_data,
`ifdef MBIST_DIAG_EN
    output logic [ERR_W-1:0] err_cnt,
`endif
    output logic [16:0]      mem_a,
    output logic             mem_oe,
    output logic [1:0]       mem_cs,
    output logic [1:0]       mem_we,
    inout  wire  [15:0]      mem_io
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [2:0] ELEM_LAST = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [2:0]  elem_q, elem_d;
    logic        op_q, op_d;
    logic [16:0] addr_q, addr_d;
    logic        fail_q, fail_d;
    logic [16:0] fail_addr_q, fail_addr_d;
    logic [15:0] fail_data_q, fail_data_d;

`ifdef MBIST_DIAG_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`else
    logic unused_err_w;
    assign unused_err_w = (ERR_W != 0);
`endif

    // Current operation attributes decoded from element and op index.
    logic        op_rd;
    logic        op_one;
    logic        op_last;
    logic        elem_up;
    logic        elem_end;
    logic [15:0] exp_data;
    logic        miscmp;
    logic        active;
    logic        drv_en;

    // Decode the March C- element table: r/w, data polarity, direction.
    always_comb begin
        op_rd   = 1'b0;
        op_one  = 1'b0;
        op_last = 1'b1;
        elem_up = 1'b1;
        case (elem_q)
            3'd0: begin
                op_rd   = 1'b0;
                op_one  = 1'b0;
                op_last = 1'b1;
            end
            3'd1: begin
                op_rd   = ~op_q;
                op_one  = op_q;
                op_last = op_q;
            end
            3'd2: begin
                op_rd   = ~op_q;
                op_one  = ~op_q;
                op_last = op_q;
            end
            3'd3: begin
                op_rd   = ~op_q;
                op_one  = op_q;
                op_last = op_q;
                elem_up = 1'b0;
            end
            3'd4: begin
                op_rd   = ~op_q;
                op_one  = ~op_q;
                op_last = op_q;
                elem_up = 1'b0;
            end
            3'd5: begin
                op_rd   = 1'b1;
                op_one  = 1'b0;
                op_last = 1'b1;
            end
            default: begin
                op_rd   = 1'b0;
                op_one  = 1'b0;
                op_last = 1'b1;
            end
        endcase
    end

    assign elem_end = elem_up ? (addr_q == ADDR_LAST)
                              : (addr_q == 17'd0);
    assign exp_data = {16{op_one}};
    assign active   = (state_q == SETUP) || (state_q == STROBE);
    assign drv_en   = active && !op_rd;
    assign miscmp   = (state_q == STROBE) && op_rd
                      && (mem_io != exp_data);

    // Sequence control, address walk and first-failure capture.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef MBIST_DIAG_EN
        err_cnt_d   = err_cnt_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SETUP;
                    elem_d      = 3'd0;
                    op_d        = 1'b0;
                    addr_d      = 17'd0;
                    fail_d      = 1'b0;
                    fail_addr_d = 17'd0;
                    fail_data_d = 16'h0000;
`ifdef MBIST_DIAG_EN
                    err_cnt_d   = '0;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d = SETUP;
                if (miscmp) begin
                    if (!fail_q) begin
                        fail_d      = 1'b1;
                        fail_addr_d = addr_q;
                        fail_data_d = mem_io;
                    end
`ifdef MBIST_DIAG_EN
                    if (!(&err_cnt_q)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
`endif
                end
                if (!op_last) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!elem_end) begin
                        addr_d = elem_up ? addr_q + 17'd1
                                         : addr_q - 17'd1;
                    end else if (elem_q == ELEM_LAST) begin
                        state_d = DONE;
                    end else begin
                        elem_d = elem_q + 3'd1;
                        // Elements 3 and 4 walk downward.
                        if (elem_q == 3'd2 || elem_q == 3'd3) begin
                            addr_d = ADDR_LAST;
                        end else begin
                            addr_d = 17'd0;
                        end
                    end
                end
`ifndef MBIST_DIAG_EN
                // Production mode stops at the first bad read.
                if (miscmp) begin
                    state_d = DONE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= 3'd0;
            op_q        <= 1'b0;
            addr_q      <= 17'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= 17'd0;
            fail_data_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

`ifdef MBIST_DIAG_EN
    // Saturating miscompare counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // Memory strobes are pure decodes of registered state so reset
    // releases the bus in the same cycle.
    assign busy      = active;
    assign done      = (state_q == DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign mem_a     = addr_q;
    assign mem_cs    = {2{active}};
    assign mem_oe    = active && op_rd;
    assign mem_we    = {2{(state_q == STROBE) && !op_rd}};
    assign mem_io    = drv_en ? exp_data : 16'hzzzz;

endmodule

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 Parameter ADDR_LAST, default 17'd3, last tested word address; range tested is 0..ADDR_LAST.
REQ-002 Parameter ERR_W, default 8, width of the error counter (present only with MBIST_DIAG_EN).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run the test; sampled in IDLE or DONE only.
REQ-006 busy  output  1  high while the March sequence runs.
REQ-007 done  output  1  level, high from test completion until next accepted start.
REQ-008 fail  output  1  sticky, high once any read miscompares in the current run.
REQ-009 fail_addr  output  17  address of first miscompare.
REQ-010 fail_data  output  16  data read at first miscompare.
REQ-011 err_cnt  output  ERR_W  saturating miscompare count (MBIST_DIAG_EN only).
REQ-012 mem_a  output  17  memory word address.
REQ-013 mem_oe  output  1  memory output enable.
REQ-014 mem_cs  output  2  byte chip selects.
REQ-015 mem_we  output  2  byte write enables.
REQ-016 mem_io  inout  16  memory data bus.

Function
REQ-017 The block SHALL run March C- in 16-bit mode: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0); 0 = 16'h0000, 1 = 16'hFFFF.
REQ-018 FSM states SHALL be IDLE, SETUP, STROBE, DONE; IDLE/DONE -> SETUP on start; SETUP -> STROBE always; STROBE -> SETUP for the next op, or -> DONE after the final op or on abort.
REQ-019 Every op SHALL take exactly 2 cycles (SETUP, STROBE) with no gap cycles, so a fault-free run keeps busy high for exactly 20*(ADDR_LAST+1) cycles.
REQ-020 mem_cs SHALL be 2'b11 in SETUP/STROBE, 2'b00 in IDLE/DONE.
REQ-021 Write op: mem_oe=0 in both cycles, mem_io driven with write data in both cycles, mem_we=2'b11 in STROBE only, 2'b00 in SETUP.
REQ-022 Read op: mem_we=2'b00, mem_oe=1 in both cycles, mem_io released (high-Z); read data SHALL be compared on the clock edge ending STROBE.
REQ-023 The block SHALL never drive mem_io while mem_oe=1; mem_io SHALL be high-Z outside write ops.
REQ-024 mem_a SHALL be stable across SETUP and STROBE of an op; up elements count 0..ADDR_LAST, down elements ADDR_LAST..0, address changes only on STROBE->SETUP.
REQ-025 On first miscompare: fail=1, fail_addr=mem_a, fail_data=sampled mem_io; later miscompares SHALL NOT overwrite them.
REQ-026 start while busy SHALL be ignored; start in DONE SHALL clear done, fail, fail_addr, fail_data (and err_cnt) and restart.
REQ-027 busy and done SHALL never be high simultaneously.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, err_cnt=0, mem_a=0, mem_oe=0, mem_cs=2'b00, mem_we=2'b00, mem_io high-Z, including mid-operation.
REQ-029 After rst_n deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-030 Macro MBIST_DIAG_EN: when defined, a miscompare SHALL NOT abort; the run completes, err_cnt increments per miscompare and saturates at all-ones.
REQ-031 Without MBIST_DIAG_EN, err_cnt SHALL not exist and the first miscompare SHALL move STROBE -> DONE on that edge, so done rises the cycle after the failing STROBE.

Verification
REQ-032 ADDR_LAST=3, fault-free memory, start pulse -> busy high exactly 80 cycles, then done=1, fail=0.
REQ-033 ADDR_LAST=3, bit 5 stuck-at-0 at address 2, no macro -> fail=1, fail_addr=17'd2, fail_data=16'hFFDF, done=1 one cycle after element-3 read of address 2.
REQ-034 Same fault with MBIST_DIAG_EN -> run completes in 80 cycles, err_cnt=2, fail_addr=17'd2, fail_data=16'hFFDF.
REQ-035 rst_n low at cycle 30 of a run -> same cycle: busy=0, mem_cs=2'b00, mem_we=2'b00, mem_oe=0, mem_io high-Z.
REQ-036 start at cycle 10 of a run -> ignored, run still ends at 80 cycles; start in DONE after failing run -> fail clears, fault-free rerun ends with fail=0.
REQ-037 Bus monitor over all runs -> no cycle with mem_oe=1 and controller driving mem_io; mem_we never nonzero in SETUP.
